scan_pos_gen: RTL and testbench

//  Generates image scan coordinates for the FAST corner pipeline. Walks the interior

---
 rtl/scan_pos_gen.sv | 178 +++++++++++++++++
 tb/tb_scan_pos_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/scan_pos_gen.sv
// Scan-coordinate generator for the FAST corner pipeline: walks the interior region
// (BORDER margin removed) in raster or serpentine order and offers each position on valid/ready.
module scan_pos_gen #(
  parameter int SIZE     = 10,
  parameter int BORDER   = 3,
  parameter int STRIDE_W = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [SIZE-1:0]     max_x,
  input  logic [SIZE-1:0]     max_y,
  output logic                busy,
  output logic                pos_valid,
  input  logic                pos_ready,
  output logic [SIZE-1:0]     curr_x,
  output logic [SIZE-1:0]     curr_y,
  output logic                row_start,
  output logic                dir,
  output logic                last,
  output logic                done,
  output logic                cfg_err
);
  localparam int              W       = SIZE + 1;
  localparam logic [W-1:0]    LO_W    = W'(BORDER);
  localparam logic [SIZE-1:0] LO      = SIZE'(BORDER);
  localparam logic [W-1:0]    MIN_DIM = W'(2 * BORDER + 1);
  localparam logic [W-1:0]    HI_OFS  = W'(BORDER + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  state_t              state_q;
  logic                mode_q;
  logic [STRIDE_W-1:0] stride_q;
  logic [SIZE-1:0]     max_x_q, max_y_q;
  logic [W-1:0]        x_acc_q, y_acc_q;
  logic [SIZE-1:0]     x_last_q, y_last_q, curr_x_q, curr_y_q;
  logic                busy_q, pos_valid_q, row_start_q, dir_q, last_q, done_q, cfg_err_q;

  logic            cfg_bad, x_adv, y_adv, handshake, row_end;
  logic [W-1:0]    x_hi, y_hi, x_step, y_step;
  logic [SIZE-1:0] stride_s, x_d, y_d;
  logic            dir_d, row_start_d, last_d;

  assign cfg_bad   = (stride == '0) || ({1'b0, max_x} < MIN_DIM) || ({1'b0, max_y} < MIN_DIM);
  // Bounds are only consulted after a valid config was latched, so they cannot underflow.
  assign x_hi      = {1'b0, max_x_q} - HI_OFS;
  assign y_hi      = {1'b0, max_y_q} - HI_OFS;
  assign x_step    = x_acc_q + W'(stride_q);
  assign y_step    = y_acc_q + W'(stride_q);
  assign x_adv     = (x_step <= x_hi);
  assign y_adv     = (y_step <= y_hi);
  assign stride_s  = SIZE'(stride_q);
  assign handshake = pos_valid_q && pos_ready;

  always_comb begin
    row_end     = dir_q ? (curr_x_q == LO) : (curr_x_q == x_last_q);
    x_d         = curr_x_q;
    y_d         = curr_y_q;
    dir_d       = dir_q;
    row_start_d = 1'b0;
    if (!row_end) begin
      x_d = dir_q ? (curr_x_q - stride_s) : (curr_x_q + stride_s);
    end else begin
      y_d         = curr_y_q + stride_s;
      row_start_d = 1'b1;
      if (mode_q) begin
        dir_d = ~dir_q;
      end else begin
        x_d   = LO;
        dir_d = 1'b0;
      end
    end
    last_d = (y_d == y_last_q) && (dir_d ? (x_d == LO) : (x_d == x_last_q));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      stride_q    <= '0;
      max_x_q     <= '0;
      max_y_q     <= '0;
      x_acc_q     <= '0;
      y_acc_q     <= '0;
      x_last_q    <= '0;
      y_last_q    <= '0;
      curr_x_q    <= '0;
      curr_y_q    <= '0;
      busy_q      <= 1'b0;
      pos_valid_q <= 1'b0;
      row_start_q <= 1'b0;
      dir_q       <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        pos_valid_q <= 1'b0;
        row_start_q <= 1'b0;
        dir_q       <= 1'b0;
        last_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (cfg_bad) begin
                cfg_err_q <= 1'b1;
              end else begin
                mode_q   <= mode;
                stride_q <= stride;
                max_x_q  <= max_x;
                max_y_q  <= max_y;
                x_acc_q  <= LO_W;
                y_acc_q  <= LO_W;
                busy_q   <= 1'b1;
                state_q  <= SETUP;
              end
            end
          end
          SETUP: begin
            if (x_adv) x_acc_q <= x_step;
            if (y_adv) y_acc_q <= y_step;
            if (!x_adv && !y_adv) begin
              x_last_q    <= x_acc_q[SIZE-1:0];
              y_last_q    <= y_acc_q[SIZE-1:0];
              curr_x_q    <= LO;
              curr_y_q    <= LO;
              dir_q       <= 1'b0;
              row_start_q <= 1'b1;
              last_q      <= (x_acc_q == LO_W) && (y_acc_q == LO_W);
              pos_valid_q <= 1'b1;
              state_q     <= SCAN;
            end
          end
          SCAN: begin
            if (handshake) begin
              if (last_q) begin
                state_q     <= DONE;
                busy_q      <= 1'b0;
                pos_valid_q <= 1'b0;
                row_start_q <= 1'b0;
                dir_q       <= 1'b0;
                last_q      <= 1'b0;
                done_q      <= 1'b1;
              end else begin
                curr_x_q    <= x_d;
                curr_y_q    <= y_d;
                dir_q       <= dir_d;
                row_start_q <= row_start_d;
                last_q      <= last_d;
              end
            end
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign pos_valid = pos_valid_q;
  assign curr_x    = curr_x_q;
  assign curr_y    = curr_y_q;
  assign row_start = row_start_q;
  assign dir       = dir_q;
  assign last      = last_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_scan_pos_gen.sv
// Directed bench for scan_pos_gen: hand-written position tables checked per handshake.
module tb_scan_pos_gen;
  localparam int SIZE     = 10;
  localparam int STRIDE_W = 4;

  logic                clk = 1'b0;
  logic                n_rst = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                mode = 1'b0;
  logic                pos_ready = 1'b1;
  logic [STRIDE_W-1:0] stride = '0;
  logic [SIZE-1:0]     max_x = '0;
  logic [SIZE-1:0]     max_y = '0;
  logic                busy, pos_valid, row_start, dir, last, done, cfg_err;
  logic [SIZE-1:0]     curr_x, curr_y;

  int          vectors = 0;
  int          miscompares = 0;
  logic [22:0] exp_q[$];

  always #5 clk = ~clk;

  scan_pos_gen #(.SIZE(SIZE), .BORDER(3), .STRIDE_W(STRIDE_W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .mode(mode),
    .stride(stride), .max_x(max_x), .max_y(max_y), .busy(busy),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .curr_x(curr_x), .curr_y(curr_y),
    .row_start(row_start), .dir(dir), .last(last), .done(done), .cfg_err(cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int x, input int y, input bit rs, input bit d, input bit l);
    exp_q.push_back({10'(x), 10'(y), rs, d, l});
  endtask

  task automatic do_start(input bit m, input int s, input int mx, input int my);
    @(negedge clk);
    mode = m; stride = STRIDE_W'(s); max_x = SIZE'(mx); max_y = SIZE'(my); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);   check({tag, "_valid"}, pos_valid, 0);
    check({tag, "_x"}, curr_x, 0);    check({tag, "_y"}, curr_y, 0);
    check({tag, "_rs"}, row_start, 0); check({tag, "_dir"}, dir, 0);
    check({tag, "_last"}, last, 0);   check({tag, "_done"}, done, 0);
    check({tag, "_err"}, cfg_err, 0);
  endtask

  // 10x9, stride 1, serpentine
  task automatic push_serp();
    push(3,3,1,0,0); push(4,3,0,0,0); push(5,3,0,0,0); push(6,3,0,0,0);
    push(6,4,1,1,0); push(5,4,0,1,0); push(4,4,0,1,0); push(3,4,0,1,0);
    push(3,5,1,0,0); push(4,5,0,0,0); push(5,5,0,0,0); push(6,5,0,0,1);
  endtask

  task automatic run_scan(input int exp_setup, input int stall_idx, input int poke_idx,
                          input int abort_idx);
    int          idx = 0;
    int          setup = 0;
    int          guard = 0;
    bit          aborted = 1'b0;
    logic [22:0] e;
    while (exp_q.size() > 0 && guard < 500) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (!pos_valid) begin
        if (idx == 0) setup++;
        else check("valid_gap", pos_valid, 1);
        continue;
      end
      if (idx == 0) check("setup_len", setup, exp_setup);
      e = exp_q[0];
      if (idx == stall_idx) begin
        pos_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_x", curr_x, e[22:13]);
          check("stall_y", curr_y, e[12:3]);
          check("stall_valid", pos_valid, 1);
        end
        pos_ready = 1'b1;
      end
      if (idx == poke_idx) begin
        start = 1'b1; mode = 1'b0; stride = 4'd2; max_x = 10'd12; max_y = 10'd12;
      end
      check("pos_x", curr_x, e[22:13]);
      check("pos_y", curr_y, e[12:3]);
      check("row_start", row_start, e[2]);
      check("dir", dir, e[1]);
      check("last", last, e[0]);
      check("busy_scan", busy, 1);
      $display("pos %0d: x=%0d y=%0d row_start=%0d dir=%0d last=%0d",
               idx, curr_x, curr_y, row_start, dir, last);
      e = exp_q.pop_front();
      if (idx == abort_idx) begin
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        start = 1'b0;
        exp_q.delete();
        aborted = 1'b1;
      end
      idx++;
    end
    check("positions_left", exp_q.size(), 0);
    @(negedge clk);
    check("end_valid", pos_valid, 0);
    check("end_busy", busy, 0);
    check("end_done", done, aborted ? 0 : 1);
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic bad_cfg(input int s, input int mx, input int my);
    do_start(1'b0, s, mx, my);
    @(negedge clk);
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_busy", busy, 0);
    @(negedge clk);
    check("cfg_err_clear", cfg_err, 0);
    repeat (4) @(negedge clk);
    check("cfg_no_valid", pos_valid, 0);
    check("cfg_busy_later", busy, 0);
    $display("bad config stride=%0d max=%0dx%0d rejected", s, mx, my);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    // serpentine walk with direction reversal on the middle row
    do_start(1'b1, 1, 10, 9);
    push_serp();
    run_scan(4, -1, -1, -1);

    // raster, stride 2: SETUP of 3 cycles
    do_start(1'b0, 2, 12, 12);
    push(3,3,1,0,0); push(5,3,0,0,0); push(7,3,0,0,0);
    push(3,5,1,0,0); push(5,5,0,0,0); push(7,5,0,0,0);
    push(3,7,1,0,0); push(5,7,0,0,0); push(7,7,0,0,1);
    run_scan(3, -1, -1, -1);

    // back-pressure at the second position
    do_start(1'b0, 1, 10, 9);
    push(3,3,1,0,0); push(4,3,0,0,0); push(5,3,0,0,0); push(6,3,0,0,0);
    push(3,4,1,0,0); push(4,4,0,0,0); push(5,4,0,0,0); push(6,4,0,0,0);
    push(3,5,1,0,0); push(4,5,0,0,0); push(5,5,0,0,0); push(6,5,0,0,1);
    run_scan(4, 1, -1, -1);

    bad_cfg(0, 10, 9);
    bad_cfg(1, 6, 9);
    bad_cfg(1, 10, 6);

    // start while busy at position 2, abort (with start) at position 5, then rescan
    do_start(1'b1, 1, 10, 9);
    push(3,3,1,0,0); push(4,3,0,0,0); push(5,3,0,0,0); push(6,3,0,0,0);
    push(6,4,1,1,0);
    run_scan(4, -1, 1, 4);
    do_start(1'b1, 1, 10, 9);
    push_serp();
    run_scan(4, -1, -1, -1);

    // asynchronous reset in the middle of a scan
    do_start(1'b0, 2, 12, 12);
    repeat (5) @(negedge clk);
    check("pre_reset_valid", pos_valid, 1);
    n_rst = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    @(negedge clk);
    n_rst = 1'b1;

    // degenerate single-position region
    do_start(1'b0, 1, 7, 7);
    push(3,3,1,0,1);
    run_scan(1, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
